// File: rtl/spi_peripheral.sv
// SPI mode-0 write-only peripheral: synchronizes the SPI pins into the clk domain,
// receives 16-bit MSB-first write frames and holds five 8-bit control registers.
module spi_peripheral #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MAX_ADDR    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_strobe
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    localparam logic [6:0] MAX_ADDR_L = 7'(MAX_ADDR);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] copi_sync;
    logic [SYNC_STAGES-1:0] ncs_sync;
    logic                   sclk_prev;
    logic                   ncs_prev;
    logic                   sclk_s;
    logic                   copi_s;
    logic                   ncs_s;
    logic                   sclk_rise;
    logic                   ncs_rise;
    logic                   ncs_fall;

    state_t      state;
    state_t      state_next;
    logic [4:0]  bit_cnt;
    logic        overflow;
    logic [15:0] shift_reg;
    logic        frame_ok;
    logic        do_shift;
    logic        do_commit;

    // ncs chain resets to 1 so release of reset never looks like a frame start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            copi_sync <= '0;
            ncs_sync  <= '1;
            sclk_prev <= 1'b0;
            ncs_prev  <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
            sclk_prev <= sclk_s;
            ncs_prev  <= ncs_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign copi_s    = copi_sync[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign ncs_rise  = ncs_s & ~ncs_prev;
    assign ncs_fall  = ~ncs_s & ncs_prev;

    assign frame_ok = (bit_cnt == 5'd16) && !overflow && shift_reg[15]
                      && (shift_reg[14:8] <= MAX_ADDR_L);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        do_shift   = 1'b0;
        do_commit  = 1'b0;
        case (state)
            IDLE: begin
                if (ncs_fall) state_next = SHIFT;
            end
            SHIFT: begin
                if (ncs_fall) begin
                    state_next = SHIFT;
                end else if (ncs_rise) begin
                    state_next = COMMIT;
                    do_commit  = frame_ok;
                end else if (sclk_rise && !ncs_s) begin
                    do_shift = 1'b1;
                end
            end
            COMMIT: begin
                state_next = ncs_fall ? SHIFT : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // bit counter saturates at 16; any later SCLK rise marks the frame as too long
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            overflow  <= 1'b0;
            shift_reg <= '0;
        end else if (ncs_fall) begin
            bit_cnt  <= '0;
            overflow <= 1'b0;
        end else if (do_shift) begin
            if (bit_cnt == 5'd16) begin
                overflow <= 1'b1;
            end else begin
                shift_reg <= {shift_reg[14:0], copi_s};
                bit_cnt   <= bit_cnt + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_reg_out_7_0  <= '0;
            en_reg_out_15_8 <= '0;
            en_reg_pwm_7_0  <= '0;
            en_reg_pwm_15_8 <= '0;
            pwm_duty_cycle  <= '0;
            wr_strobe       <= 1'b0;
        end else begin
            wr_strobe <= do_commit;
            if (do_commit) begin
                case (shift_reg[14:8])
                    7'd0:    en_reg_out_7_0  <= shift_reg[7:0];
                    7'd1:    en_reg_out_15_8 <= shift_reg[7:0];
                    7'd2:    en_reg_pwm_7_0  <= shift_reg[7:0];
                    7'd3:    en_reg_pwm_15_8 <= shift_reg[7:0];
                    7'd4:    pwm_duty_cycle  <= shift_reg[7:0];
                    default: ;
                endcase
            end
        end
    end

endmodule
